// File: rtl/detection_scheduler_if.sv
// Bundle of signals between the detection scheduler, the classifier bank,
// the integral-image buffer and the frame-level controller.
interface detection_scheduler_if #(
  parameter int NUM_CLS = 4
);
  logic                  start;
  logic [NUM_CLS-1:0]    cls_detect_en;
  logic [NUM_CLS-1:0]    cls_detect_done;
  logic [NUM_CLS-1:0]    cls_flag;
  logic [NUM_CLS*15-1:0] cls_rd_addr;
  logic [14:0]           buf_rd_addr;
  logic                  busy;
  logic                  hit_valid;
  logic [7:0]            hit_x;
  logic [6:0]            hit_y;
  logic [15:0]           hit_count;
  logic                  scan_done;
  logic                  timeout_err;

  modport master (
    input  start, cls_detect_done, cls_flag, cls_rd_addr,
    output cls_detect_en, buf_rd_addr, busy, hit_valid, hit_x, hit_y,
           hit_count, scan_done, timeout_err
  );

  modport slave (
    output start, cls_detect_done, cls_flag, cls_rd_addr,
    input  cls_detect_en, buf_rd_addr, busy, hit_valid, hit_x, hit_y,
           hit_count, scan_done, timeout_err
  );
endinterface

// File: rtl/detection_scheduler.sv
// Sweeps a detection window over the integral image and runs the classifier
// cascade at each position, granting the active stage the buffer read port.
module detection_scheduler #(
  parameter int NUM_CLS   = 4,
  parameter int II_WIDTH  = 160,
  parameter int II_HEIGHT = 120,
  parameter int WIN_W     = 24,
  parameter int WIN_H     = 24,
  parameter int STEP      = 4,
  parameter int TIMEOUT   = 32
) (
  input logic clk,
  input logic rst,
  detection_scheduler_if.master bus
);
  localparam int AW       = 15;
  localparam int SW       = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1;
  localparam int CW       = $clog2(TIMEOUT + 1);
  localparam int ROW_STEP = STEP * II_WIDTH;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_DONE, EVAL, ADVANCE, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         win_x_q, win_x_d;
  logic [6:0]         win_y_q, win_y_d;
  logic [AW-1:0]      win_base_q, win_base_d;
  logic [AW-1:0]      row_base_q, row_base_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic [SW-1:0]      grant_q, grant_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic               pass_q, pass_d;
  logic [NUM_CLS-1:0] en_q, en_d;
  logic               busy_q, busy_d;
  logic               hit_valid_q, hit_valid_d;
  logic [7:0]         hit_x_q, hit_x_d;
  logic [6:0]         hit_y_q, hit_y_d;
  logic [15:0]        hit_count_q, hit_count_d;
  logic               scan_done_q, scan_done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [AW-1:0]      sel_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      win_x_q       <= '0;
      win_y_q       <= '0;
      win_base_q    <= '0;
      row_base_q    <= '0;
      stage_q       <= '0;
      grant_q       <= '0;
      wcnt_q        <= '0;
      pass_q        <= 1'b0;
      en_q          <= '0;
      busy_q        <= 1'b0;
      hit_valid_q   <= 1'b0;
      hit_x_q       <= '0;
      hit_y_q       <= '0;
      hit_count_q   <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      win_x_q       <= win_x_d;
      win_y_q       <= win_y_d;
      win_base_q    <= win_base_d;
      row_base_q    <= row_base_d;
      stage_q       <= stage_d;
      grant_q       <= grant_d;
      wcnt_q        <= wcnt_d;
      pass_q        <= pass_d;
      en_q          <= en_d;
      busy_q        <= busy_d;
      hit_valid_q   <= hit_valid_d;
      hit_x_q       <= hit_x_d;
      hit_y_q       <= hit_y_d;
      hit_count_q   <= hit_count_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    win_x_d       = win_x_q;
    win_y_d       = win_y_q;
    win_base_d    = win_base_q;
    row_base_d    = row_base_q;
    stage_d       = stage_q;
    grant_d       = grant_q;
    wcnt_d        = wcnt_q;
    pass_d        = pass_q;
    en_d          = '0;
    busy_d        = busy_q;
    hit_valid_d   = 1'b0;
    hit_x_d       = hit_x_q;
    hit_y_d       = hit_y_q;
    hit_count_d   = hit_count_q;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          win_x_d       = '0;
          win_y_d       = '0;
          win_base_d    = '0;
          row_base_d    = '0;
          stage_d       = '0;
          hit_count_d   = '0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = ARM;
        end
      end
      // The trigger is registered, so it lands in the first WAIT_DONE cycle.
      ARM: begin
        en_d    = NUM_CLS'(1) << stage_q;
        wcnt_d  = '0;
        grant_d = stage_q;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.cls_detect_done[stage_q]) begin
          pass_d  = bus.cls_flag[stage_q];
          state_d = EVAL;
        end else if (wcnt_q == CW'(TIMEOUT - 1)) begin
          pass_d        = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = EVAL;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      EVAL: begin
        if (pass_q && (stage_q != SW'(NUM_CLS - 1))) begin
          stage_d = stage_q + 1'b1;
          state_d = ARM;
        end else begin
          if (pass_q) begin
            hit_valid_d = 1'b1;
            hit_x_d     = win_x_q;
            hit_y_d     = win_y_q;
            if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
          end
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        stage_d = '0;
        if (32'(win_x_q) + STEP <= II_WIDTH - WIN_W) begin
          win_x_d    = win_x_q + 8'(STEP);
          win_base_d = win_base_q + AW'(STEP);
          state_d    = ARM;
        end else if (32'(win_y_q) + STEP <= II_HEIGHT - WIN_H) begin
          win_x_d    = '0;
          win_y_d    = win_y_q + 7'(STEP);
          row_base_d = row_base_q + AW'(ROW_STEP);
          win_base_d = row_base_q + AW'(ROW_STEP);
          state_d    = ARM;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        scan_done_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Unregistered on purpose: classifiers count on a fixed buffer latency.
  assign sel_addr        = bus.cls_rd_addr[32'(grant_q) * AW +: AW];
  assign bus.buf_rd_addr = sel_addr + win_base_q;

  assign bus.cls_detect_en = en_q;
  assign bus.busy          = busy_q;
  assign bus.hit_valid     = hit_valid_q;
  assign bus.hit_x         = hit_x_q;
  assign bus.hit_y         = hit_y_q;
  assign bus.hit_count     = hit_count_q;
  assign bus.scan_done     = scan_done_q;
  assign bus.timeout_err   = timeout_err_q;
endmodule

// File: tb/tb_detection_scheduler.sv
// Self-checking bench for detection_scheduler: stub classifiers answer each
// trigger, and expected hits are queued at start and popped as hits arrive.
module tb_detection_scheduler;
  localparam int NUM_CLS = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  detection_scheduler_if #(.NUM_CLS(NUM_CLS)) bus();

  detection_scheduler #(.NUM_CLS(NUM_CLS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  int vectors = 0;
  int miscompares = 0;

  int          delayCfg;
  logic [3:0]  neverDone;
  logic [3:0]  rejectAll;
  bit          acceptOnly84;
  bit          spurious3;
  int          win0Count;
  int          curWin;
  int          enCount[4];
  bit          active[4];
  int          cnt[4];
  logic [14:0] expQ[$];

  // Stub classifiers: answer delayCfg cycles after their trigger.
  always @(negedge clk) begin
    logic [3:0] d;
    logic [3:0] f;
    d = '0;
    f = '0;
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        active[k] = 1'b0;
      end else if (bus.cls_detect_en[k]) begin
        active[k] = 1'b1;
        cnt[k] = 0;
        enCount[k]++;
        if (k == 0) begin
          curWin = win0Count;
          win0Count++;
        end
      end else if (active[k]) begin
        cnt[k]++;
        if (cnt[k] >= delayCfg) begin
          active[k] = 1'b0;
          if (!neverDone[k]) begin
            d[k] = 1'b1;
            f[k] = !rejectAll[k] && !(k == 0 && acceptOnly84 && curWin != 37);
          end
        end
      end
    end
    if (spurious3 && active[0] && cnt[0] == 1) begin
      d[3] = 1'b1;
      f[3] = 1'b1;
      f[0] = 1'b1;
    end
    bus.cls_detect_done = d;
    bus.cls_flag = f;
  end

  task automatic configure(input int dly, input logic [3:0] nd, input logic [3:0] rj,
                           input bit only84, input bit spur);
    delayCfg = dly;
    neverDone = nd;
    rejectAll = rj;
    acceptOnly84 = only84;
    spurious3 = spur;
    win0Count = 0;
    curWin = -1;
    for (int k = 0; k < 4; k++) begin
      enCount[k] = 0;
      active[k] = 1'b0;
      cnt[k] = 0;
    end
    expQ.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({bus.cls_detect_en, bus.busy, bus.hit_valid, bus.scan_done, bus.hit_count,
         bus.timeout_err, bus.hit_x, bus.hit_y} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: en=%b busy=%b hv=%b sd=%b cnt=%0d te=%b x=%0d y=%0d, all required 0",
               bus.cls_detect_en, bus.busy, bus.hit_valid, bus.scan_done, bus.hit_count,
               bus.timeout_err, bus.hit_x, bus.hit_y);
    end
    vectors++;
    if (bus.buf_rd_addr !== 15'd25) begin
      miscompares++;
      $display("[TB] FAIL reset_addr: got %0d, required 25", bus.buf_rd_addr);
    end
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_full_scan();
    int hits;
    int dones;
    int extra;
    logic [14:0] last;
    logic [14:0] exp;
    configure(11, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int y = 0; y <= 96; y += 4)
      for (int x = 0; x <= 136; x += 4)
        expQ.push_back({8'(x), 7'(y)});
    pulse_start();
    vectors++;
    if (bus.busy !== 1'b1 || bus.cls_detect_en !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL start_latency1: busy=%b en=%b, required busy=1 en=0000", bus.busy, bus.cls_detect_en);
    end
    @(negedge clk); #1;
    vectors++;
    if (bus.cls_detect_en !== 4'b0001) begin
      miscompares++;
      $display("[TB] FAIL start_latency2: en=%b, required 0001", bus.cls_detect_en);
    end
    hits = 0;
    dones = 0;
    last = '0;
    for (int cyc = 0; cyc < 52000 && dones == 0; cyc++) begin
      bus.start = (cyc == 300);
      @(negedge clk); #1;
      if (bus.hit_valid) begin
        hits++;
        last = {bus.hit_x, bus.hit_y};
        exp = (expQ.size() > 0) ? expQ.pop_front() : 15'h7FFF;
        vectors++;
        if (last !== exp) begin
          miscompares++;
          $display("[TB] FAIL full_hit_pos: got (%0d,%0d), required (%0d,%0d)",
                   bus.hit_x, bus.hit_y, exp[14:7], exp[6:0]);
        end
        vectors++;
        if (bus.hit_count !== 16'(hits)) begin
          miscompares++;
          $display("[TB] FAIL full_hit_count_step: got %0d, required %0d", bus.hit_count, hits);
        end
      end
      if (bus.scan_done) begin
        dones++;
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL full_busy_fall: busy=%b at scan_done, required 0", bus.busy);
        end
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (dones != 1 || hits != 875 || bus.hit_count !== 16'd875) begin
      miscompares++;
      $display("[TB] FAIL full_totals: dones=%0d hits=%0d hit_count=%0d, required 1/875/875",
               dones, hits, bus.hit_count);
    end
    vectors++;
    if (last !== {8'd136, 7'd96} || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL full_last_hit: got (%0d,%0d) with %0d left, required (136,96) with 0 left",
               last[14:7], last[6:0], expQ.size());
    end
    extra = 0;
    repeat (60) begin
      @(negedge clk); #1;
      if (bus.scan_done || bus.busy) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("[TB] FAIL ignored_start: %0d busy/scan_done cycles after scan, required 0", extra);
    end
  endtask

  task automatic test_stage1_reject();
    int hits;
    int dones;
    configure(2, 4'b0000, 4'b0010, 1'b0, 1'b0);
    pulse_start();
    hits = 0;
    dones = 0;
    for (int cyc = 0; cyc < 20000 && dones == 0; cyc++) begin
      @(negedge clk); #1;
      if (bus.hit_valid) hits++;
      if (bus.scan_done) dones++;
    end
    vectors++;
    if (dones != 1 || hits != 0 || bus.hit_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reject_totals: dones=%0d hits=%0d hit_count=%0d, required 1/0/0",
               dones, hits, bus.hit_count);
    end
    vectors++;
    if (enCount[0] != 875 || enCount[1] != 875 || enCount[2] != 0 || enCount[3] != 0) begin
      miscompares++;
      $display("[TB] FAIL reject_early_exit: en counts %0d/%0d/%0d/%0d, required 875/875/0/0",
               enCount[0], enCount[1], enCount[2], enCount[3]);
    end
  endtask

  task automatic test_single_window();
    int hits;
    int dones;
    bit addrChecked;
    logic [14:0] exp;
    configure(2, 4'b0000, 4'b0000, 1'b1, 1'b0);
    expQ.push_back({8'd8, 7'd4});
    pulse_start();
    hits = 0;
    dones = 0;
    addrChecked = 1'b0;
    for (int cyc = 0; cyc < 30000 && dones == 0; cyc++) begin
      @(negedge clk); #1;
      if (!addrChecked && active[0] && curWin == 37) begin
        addrChecked = 1'b1;
        vectors++;
        if (bus.buf_rd_addr !== 15'd673) begin
          miscompares++;
          $display("[TB] FAIL window_addr: got %0d, required 673", bus.buf_rd_addr);
        end
      end
      if (bus.hit_valid) begin
        hits++;
        exp = (expQ.size() > 0) ? expQ.pop_front() : 15'h7FFF;
        vectors++;
        if ({bus.hit_x, bus.hit_y} !== exp) begin
          miscompares++;
          $display("[TB] FAIL single_hit_pos: got (%0d,%0d), required (%0d,%0d)",
                   bus.hit_x, bus.hit_y, exp[14:7], exp[6:0]);
        end
      end
      if (bus.scan_done) dones++;
    end
    vectors++;
    if (dones != 1 || hits != 1 || bus.hit_count !== 16'd1 || !addrChecked) begin
      miscompares++;
      $display("[TB] FAIL single_totals: dones=%0d hits=%0d hit_count=%0d addr_seen=%0d, required 1/1/1/1",
               dones, hits, bus.hit_count, addrChecked);
    end
  endtask

  task automatic test_timeout_and_midscan_reset();
    int t2;
    int tt;
    int dones;
    int seen;
    int extra;
    configure(2, 4'b0100, 4'b0000, 1'b0, 1'b0);
    pulse_start();
    t2 = -1;
    tt = -1;
    for (int cyc = 0; cyc < 2000 && tt < 0; cyc++) begin
      @(negedge clk); #1;
      if (bus.cls_detect_en[2] && t2 < 0) t2 = cyc;
      if (bus.timeout_err) tt = cyc;
    end
    vectors++;
    if (t2 < 0 || tt - t2 != 32) begin
      miscompares++;
      $display("[TB] FAIL timeout_wait: en2 at %0d, timeout_err at %0d, required 32 cycles apart", t2, tt);
    end
    vectors++;
    if (enCount[3] != 0 || bus.hit_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL timeout_cascade: en3 count %0d hit_count %0d, required 0/0", enCount[3], bus.hit_count);
    end
    neverDone = 4'b0000;
    rejectAll = 4'b0001;
    dones = 0;
    for (int cyc = 0; cyc < 20000 && dones == 0; cyc++) begin
      @(negedge clk); #1;
      if (bus.scan_done) dones++;
    end
    vectors++;
    if (dones != 1 || bus.timeout_err !== 1'b1 || bus.hit_count !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL timeout_sticky: dones=%0d timeout_err=%b hit_count=%0d, required 1/1/0",
               dones, bus.timeout_err, bus.hit_count);
    end
    configure(2, 4'b0100, 4'b0000, 1'b0, 1'b0);
    pulse_start();
    vectors++;
    if (bus.timeout_err !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_clear: timeout_err=%b busy=%b, required 0/1", bus.timeout_err, bus.busy);
    end
    seen = 0;
    for (int cyc = 0; cyc < 200 && seen == 0; cyc++) begin
      @(negedge clk); #1;
      if (bus.cls_detect_en[2]) seen = 1;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++;
    if (seen != 1 || {bus.cls_detect_en, bus.busy, bus.hit_valid, bus.scan_done, bus.hit_count,
         bus.timeout_err, bus.hit_x, bus.hit_y} !== '0 || bus.buf_rd_addr !== 15'd25) begin
      miscompares++;
      $display("[TB] FAIL midscan_reset: seen=%0d en=%b busy=%b cnt=%0d te=%b addr=%0d, required 1/0/0/0/0/25",
               seen, bus.cls_detect_en, bus.busy, bus.hit_count, bus.timeout_err, bus.buf_rd_addr);
    end
    rst = 1'b0;
    extra = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (bus.scan_done || bus.busy || bus.cls_detect_en != 0) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: %0d active cycles, required 0", extra);
    end
  endtask

  task automatic test_spurious_done();
    int hits;
    int dones;
    configure(3, 4'b0000, 4'b0001, 1'b0, 1'b1);
    pulse_start();
    hits = 0;
    dones = 0;
    for (int cyc = 0; cyc < 20000 && dones == 0; cyc++) begin
      @(negedge clk); #1;
      if (bus.hit_valid) hits++;
      if (bus.scan_done) dones++;
    end
    vectors++;
    if (dones != 1 || hits != 0 || enCount[0] != 875 || enCount[1] != 0) begin
      miscompares++;
      $display("[TB] FAIL spurious_done: dones=%0d hits=%0d en0=%0d en1=%0d, required 1/0/875/0",
               dones, hits, enCount[0], enCount[1]);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cls_rd_addr = {15'd311, 15'd207, 15'd103, 15'd25};
    configure(2, 4'b0000, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_full_scan();
    test_stage1_reject();
    test_single_window();
    test_timeout_and_midscan_reset();
    test_spurious_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
